// File: rtl/mux_pkg.sv
// Shared encodings for the scanning channel multiplexer.
package mux_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Counts 0..DWELL-1 while enabled; tick marks the last cycle of each dwell period.
module dwell_counter #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CW'(DWELL - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr || tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and dwell-timed auto scan.
module mux_scan_n
   import mux_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned W     = 8,
   parameter int unsigned DWELL = 4,
   localparam int unsigned SW   = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [SW-1:0]     sel,
   input  logic [N_CH*W-1:0] din,
   output logic [W-1:0]      y,
   output logic [SW-1:0]     ch,
   output logic              valid,
   output logic              wrap,
   output logic              sel_err
);

   state_e        state_q, state_d;
   logic [SW-1:0] cur_q, cur_d, cur, ch_q, ch_d;
   logic [W-1:0]  y_q, y_d;
   logic          valid_q, valid_d, wrap_q, wrap_d, err_q, err_d;
   logic          tick, dwell_clr, dwell_en;

   always_comb begin
      state_d = IDLE;
      if (en) begin
         state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
      end
   end

   assign dwell_en  = (state_d == SCAN);
   assign dwell_clr = !dwell_en;

   dwell_counter #(
      .DWELL(DWELL)
   ) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (dwell_clr),
      .en  (dwell_en),
      .tick(tick)
   );

   // cur_q runs one step ahead of ch after a tick; on scan entry start from the shown channel.
   assign cur = (state_q == SCAN) ? cur_q : ch_q;

   always_comb begin
      y_d     = y_q;
      ch_d    = ch_q;
      cur_d   = cur_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_d)
         MANUAL: begin
            if (32'(sel) < N_CH) begin
               y_d     = din[int'(sel)*W +: W];
               ch_d    = sel;
               valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         SCAN: begin
            y_d     = din[int'(cur)*W +: W];
            ch_d    = cur;
            valid_d = 1'b1;
            wrap_d  = (state_q == SCAN) && (cur_q != ch_q) && (cur_q == '0);
            cur_d   = cur;
            if (tick) begin
               cur_d = (cur == SW'(N_CH - 1)) ? '0 : cur + SW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         ch_q    <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         ch_q    <= ch_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign y       = y_q;
   assign ch      = ch_q;
   assign valid   = valid_q;
   assign wrap    = wrap_q;
   assign sel_err = err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomised and directed check of mux_scan_n against a cycle-level behavioural model.
module tb_mux_scan_n;

   logic        clk = 1'b0;
   logic        rst, en, mode;
   logic [1:0]  sel;
   logic [31:0] din;
   logic [7:0]  y4, y3;
   logic [1:0]  ch4, ch3;
   logic        valid4, wrap4, err4, valid3, wrap3, err3;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state, index 0: N_CH=4/DWELL=3, index 1: N_CH=3/DWELL=1.
   int m_y[2], m_ch[2], m_valid[2], m_wrap[2], m_err[2], m_scan[2], m_shown[2];

   always #5 clk = ~clk;

   mux_scan_n #(.N_CH(4), .W(8), .DWELL(3)) dut4 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din),
      .y(y4), .ch(ch4), .valid(valid4), .wrap(wrap4), .sel_err(err4)
   );

   mux_scan_n #(.N_CH(3), .W(8), .DWELL(1)) dut3 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din[23:0]),
      .y(y3), .ch(ch3), .valid(valid3), .wrap(wrap3), .sel_err(err3)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_y[i] = 0; m_ch[i] = 0; m_valid[i] = 0; m_wrap[i] = 0;
         m_err[i] = 0; m_scan[i] = 0; m_shown[i] = 0;
      end
   endtask

   // One clock edge: shown counts cycles spent on the current channel in this scan stint.
   task automatic model_step(input int i, input int n, input int dw);
      int c;
      m_valid[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
      if (!en) begin
         m_scan[i] = 0;
      end else if (!mode) begin
         m_scan[i] = 0;
         if (int'(sel) < n) begin
            m_y[i] = int'(din[int'(sel)*8 +: 8]);
            m_ch[i] = int'(sel);
            m_valid[i] = 1;
         end else begin
            m_err[i] = 1;
         end
      end else begin
         c = m_ch[i];
         if (m_scan[i] == 0) begin
            m_scan[i] = 1;
            m_shown[i] = 0;
         end else if (m_shown[i] == dw) begin
            c = (c + 1) % n;
            m_shown[i] = 0;
            m_wrap[i] = (c == 0) ? 1 : 0;
         end
         m_shown[i]++;
         m_ch[i] = c;
         m_y[i] = int'(din[c*8 +: 8]);
         m_valid[i] = 1;
      end
   endtask

   task automatic compare_all();
      check_eq("y4", int'(y4), m_y[0]);
      check_eq("ch4", int'(ch4), m_ch[0]);
      check_eq("valid4", int'(valid4), m_valid[0]);
      check_eq("wrap4", int'(wrap4), m_wrap[0]);
      check_eq("sel_err4", int'(err4), m_err[0]);
      check_eq("y3", int'(y3), m_y[1]);
      check_eq("ch3", int'(ch3), m_ch[1]);
      check_eq("valid3", int'(valid3), m_valid[1]);
      check_eq("wrap3", int'(wrap3), m_wrap[1]);
      check_eq("sel_err3", int'(err3), m_err[1]);
   endtask

   // Inputs are set while clk is low; outputs are checked on the falling edge.
   task automatic step();
      @(posedge clk);
      model_step(0, 4, 3);
      model_step(1, 3, 1);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_all();
      rst = 1'b0;
   endtask

   initial begin
      int seq[13];
      int guard;
      seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; din = 32'h44332211;
      do_reset();

      // Manual select
      en = 1'b1; mode = 1'b0; sel = 2'd2;
      step();
      check_eq("manual_y", int'(y4), 'h33);
      check_eq("manual_ch", int'(ch4), 2);

      // Scan from reset with wrap
      do_reset();
      mode = 1'b1;
      for (int k = 0; k < 13; k++) begin
         step();
         check_eq("scan_ch", int'(ch4), seq[k]);
         check_eq("scan_wrap", int'(wrap4), (k == 12) ? 1 : 0);
      end

      // Mode switching at ch=2
      for (int k = 0; k < 7; k++) step();
      check_eq("pre_switch_ch", int'(ch4), 2);
      mode = 1'b0; sel = 2'd0;
      step();
      check_eq("switch_manual_ch", int'(ch4), 0);
      mode = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("switch_scan_ch", int'(ch4), (k == 3) ? 1 : 0);
      end

      // Enable hold at ch=1
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("hold_valid", int'(valid4), 0);
         check_eq("hold_ch", int'(ch4), 1);
      end
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("resume_ch", int'(ch4), (k == 3) ? 2 : 1);
      end

      // Out-of-range select on the 3-channel instance
      mode = 1'b0; sel = 2'd3;
      step();
      check_eq("oor_err", int'(err3), 1);
      check_eq("oor_valid", int'(valid3), 0);

      // Asynchronous reset mid-scan at ch=3
      mode = 1'b1;
      guard = 0;
      while (m_ch[0] != 3 && guard < 20) begin
         step();
         guard++;
      end
      check_eq("reach_ch3", int'(ch4), 3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      step();
      check_eq("post_rst_ch", int'(ch4), 0);

      // Random traffic
      for (int k = 0; k < 800; k++) begin
         en = ($urandom_range(0, 11) != 0);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel = 2'($urandom_range(0, 3));
         din = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, range 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel.
REQ-003 SHALL have parameter DWELL, default 4: cycles per channel in scan mode, range 1..255.
REQ-004 SHALL define SW = clog2(N_CH) as the select width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: run enable.
REQ-008 SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto scan.
REQ-009 SHALL have port sel, input, SW bits: manual channel select.
REQ-010 SHALL have port din, input, N_CH*W bits: channel k occupies din[k*W +: W].
REQ-011 SHALL have port y, output, W bits: registered selected data.
REQ-012 SHALL have port ch, output, SW bits: channel index that produced y.
REQ-013 SHALL have port valid, output, 1 bit: y/ch hold fresh data this cycle.
REQ-014 SHALL have port wrap, output, 1 bit: one-cycle pulse when scan advances from N_CH-1 to 0.
REQ-015 SHALL have port sel_err, output, 1 bit: manual sel >= N_CH was sampled.

Function
REQ-016 SHALL implement FSM states IDLE, MANUAL, SCAN.
REQ-017 SHALL transition to IDLE from any state whenever en=0.
REQ-018 SHALL, when en=1, enter MANUAL if mode=0 and SCAN if mode=1, evaluated every cycle.
REQ-019 SHALL, in IDLE, hold y and ch at their last values, drive valid=0, and drive wrap=0.
REQ-020 SHALL, in MANUAL, register din[sel] into y and sel into ch; both are visible 1 cycle after sel/din are sampled, with valid=1.
REQ-021 SHALL, in MANUAL with sel >= N_CH, hold y and ch, drive valid=0, and assert sel_err for that cycle.
REQ-022 SHALL, in SCAN, keep a dwell counter 0..DWELL-1 and advance the current channel by 1 when the counter equals DWELL-1.
REQ-023 SHALL, in SCAN, wrap the current channel from N_CH-1 to 0 and assert wrap in the same cycle that ch first shows 0.
REQ-024 SHALL, in SCAN, register din[current channel] into y every cycle with valid=1, so y tracks live data during the dwell.
REQ-025 SHALL, on MANUAL->SCAN, begin scanning from the current ch value with the dwell counter cleared to 0.
REQ-026 SHALL, on SCAN->MANUAL, clear the dwell counter and take sel in the first MANUAL cycle.
REQ-027 SHALL, on IDLE->SCAN, resume from the held ch with the dwell counter at 0.
REQ-028 SHALL, when DWELL=1, advance the channel every cycle.
REQ-029 SHALL use outputs that are all registered, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, on rst=1, asynchronously force state=IDLE, y=0, ch=0, valid=0, wrap=0, sel_err=0, and dwell counter=0.
REQ-031 SHALL, on rst asserted mid-scan, abandon the dwell; after release, scanning restarts at channel 0.
REQ-032 SHALL make the first state update after rst deasserts occur on the next rising clk edge.

Structure
REQ-033 SHALL place state encodings (IDLE=2'd0, MANUAL=2'd1, SCAN=2'd2) and mode constants in shared package mux_pkg.
REQ-034 SHALL implement the dwell counter as sub-module dwell_counter, parametrised by DWELL, with inputs clk, rst, clr, en and output tick.
REQ-035 SHALL keep the channel select decode in the top level as an indexed part-select of din.

Verification (N_CH=4, W=8, DWELL=3 unless stated)
REQ-036 SHALL cover manual select: din = {8'h44, 8'h33, 8'h22, 8'h11}, en=1, mode=0, sel=2 -> next cycle y=8'h33, ch=2, valid=1.
REQ-037 SHALL cover scan with wrap: en=1, mode=1 from reset -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap=1 only on the cycle ch returns to 0.
REQ-038 SHALL cover an out-of-range select: N_CH=3, mode=0, sel=3 -> sel_err=1, valid=0, y/ch unchanged.
REQ-039 SHALL cover mode switching: in SCAN at ch=2, dwell count 1, switch mode=0 with sel=0 -> next cycle ch=0; switch back to mode=1 -> ch stays 0 for 3 cycles, then 1.
REQ-040 SHALL cover reset mid-scan: assert rst while ch=3 between clock edges -> outputs zero immediately; release rst -> scan restarts at ch=0.
REQ-041 SHALL cover enable hold: en=0 at ch=1 for 5 cycles -> valid=0, y/ch frozen; en=1 -> ch=1 for a full DWELL, then 2.
